instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction memory read by instruction_fetch.
//  - Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words, writes them to consecutive word addresses from 0.
//  - Holds the fetch stage in reset while loading. Releases it when loading is finished, so the PC restarts at address 0 on the new program.
// PARAMETERS
//  ADDR_W   10   word-address width of instruction memory (2^ADDR_W words)
// PORTS
//  Clk          in   1         system clock, rising edge
//  Reset        in   1         asynchronous, active-high reset
//  Start        in   1         1-cycle pulse: begin load (ignored while Busy)
//  Word_Count   in   ADDR_W+1  words to load, sampled on Start
//  Byte_In      in   8         stream data byte
//  Byte_Valid   in   1         Byte_In valid
//  Byte_Ready   out  1         loader accepts Byte_In this cycle
//  Mem_WrEn     out  1         instruction memory write strobe
//  Mem_Addr     out  ADDR_W    word address (= PC[ADDR_W+1:2] on the read side)
//  Mem_Data     out  32        write data
//  Fetch_Reset  out  1         drive to instruction_fetch Reset (OR with system Reset)
//  Busy         out  1         load in progress
//  Done         out  1         last load complete; held until next accepted Start
//  Err          out  1         checksum mismatch on last load (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0 except Fetch_Reset=1.
//  - FSM is in IDLE; byte counter, word counter and address are 0.
//  - Fetch_Reset drops on the first clock edge after Reset deasserts.
//  States: IDLE, RECV, WRITE, CHECK (only with macro), DONE. All outputs are registered.
//  - IDLE/DONE + Start:
//    - Word_Count==0 -> DONE immediately (Done=1, no writes).
//    - Otherwise latch count, clamped to 2^ADDR_W. Clear Done/Err and address -> RECV.
//  - RECV:
//    - Byte_Ready=1. A byte transfers when Byte_Valid && Byte_Ready.
//    - The k-th byte of a word (k=0..3) goes to bits [8k+7:8k].
//    - The 4th byte -> WRITE.
//  - WRITE (exactly 1 cycle):
//    - Mem_WrEn=1, Byte_Ready=0.
//    - Next: Mem_Addr+1 -> RECV if words remain; else CHECK if macro defined, else DONE.
//  - DONE: Done=1. Stays until Start.
//  Fetch_Reset:
//  - 1 in RECV/WRITE/CHECK, 0 in IDLE/DONE.
//  - Busy = Fetch_Reset outside reset.
//  Latency: Mem_WrEn rises the cycle after the 4th byte is accepted. Peak throughput is 1 word / 5 cycles.
//  Stalls: Byte_Valid low in RECV holds state; partial-word bytes are kept.
//  Start while Busy: ignored, no effect on state or outputs.
//  Address wrap: cannot occur, because the count is clamped to 2^ADDR_W.
//  Reset mid-load:
//  - Returns to IDLE immediately; partial word discarded.
//  - Words already written stay in memory. Done=0.
// CONFIGURATION
//  Macro LOADER_CHECKSUM_EN.
//  Defined:
//  - After the last WRITE, enter CHECK with Byte_Ready=1 and accept one checksum byte.
//  - Err=1 in DONE iff (sum of all data bytes + checksum byte) mod 256 != 0.
//  - Fetch_Reset stays 1 until that byte arrives.
//  Undefined: no CHECK state, no running sum; Err is tied to 0.
// TESTING
//  1. Reset=1 for 3 cycles, then 0 -> all outputs 0 except Fetch_Reset=1; Fetch_Reset=0 one edge later.
//  2. Start, Word_Count=2, bytes 78 56 34 12 EF BE AD DE back-to-back
//     -> writes addr0=0x12345678, addr1=0xDEADBEEF.
//     -> Mem_WrEn exactly 1 cycle each; Done=1 and Fetch_Reset=0 after the second write.
//  3. Same load with Byte_Valid low for 3 cycles after byte 2 -> identical writes, delayed by 3 cycles.
//  4. Word_Count=0 -> Done=1 the next cycle, no Mem_WrEn, Fetch_Reset stays 0.
//  5. Reset pulse after 6 bytes of a 2-word load:
//     -> only addr0 written; state IDLE, Done=0.
//     -> A new Start + 4 bytes rewrites addr0.
//  6. LOADER_CHECKSUM_EN, 1 word 01 02 03 04:
//     -> checksum 0xF6 gives Err=0; checksum 0x00 gives Err=1; Done=1 in both cases.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Purpose: packs a byte stream little-endian into 32-bit words and writes them to instruction memory from word 0, holding fetch in reset meanwhile.
// Latency: Mem_WrEn rises the cycle after the 4th byte of a word is accepted; peak rate is 1 word per 5 cycles.
// Backpressure: Byte_Ready is high only in RECV (and CHECK); Byte_Valid low simply holds state. Optional checksum via LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Word_Count,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Mem_WrEn,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_Data,
    output logic              Fetch_Reset,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    // Count is clamped to the memory size, so the address can never wrap.
    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_WORD  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              ready_d, wren_d, frst_d, done_d;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

    assign xfer = Byte_Valid && Byte_Ready;

    // Next-state, datapath and next registered-output decode.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
`ifdef LOADER_CHECKSUM_EN
                    err_d = 1'b0;
                    sum_d = 8'd0;
`endif
                    if (Word_Count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        words_d    = (Word_Count > MAX_WORDS) ? MAX_WORDS : Word_Count;
                        addr_d     = '0;
                        byte_cnt_d = 2'd0;
                        state_d    = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (xfer) begin
                    case (byte_cnt_q)
                        2'd0:    data_d[7:0]   = Byte_In;
                        2'd1:    data_d[15:8]  = Byte_In;
                        2'd2:    data_d[23:16] = Byte_In;
                        default: data_d[31:24] = Byte_In;
                    endcase
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + Byte_In;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q - ONE_WORD;
                if (words_q != ONE_WORD) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_RECV;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    err_d   = ((sum_q + Byte_In) != 8'd0);
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of the decode of the next state.
`ifdef LOADER_CHECKSUM_EN
        ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
        frst_d  = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
`else
        ready_d = (state_d == S_RECV);
        frst_d  = (state_d == S_RECV) || (state_d == S_WRITE);
`endif
        wren_d = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers; fetch is held in reset while Reset is high.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= 2'd0;
            words_q     <= '0;
            addr_q      <= '0;
            data_q      <= 32'd0;
            Byte_Ready  <= 1'b0;
            Mem_WrEn    <= 1'b0;
            Fetch_Reset <= 1'b1;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            Byte_Ready  <= ready_d;
            Mem_WrEn    <= wren_d;
            Fetch_Reset <= frst_d;
            Busy        <= frst_d;
            Done        <= done_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running byte sum and the checksum verdict of the last load.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign Mem_Addr = addr_q;
    assign Mem_Data = data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [ADDR_W:0]   Word_Count;
    logic [7:0]        Byte_In;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              Mem_WrEn;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_Data;
    logic              Fetch_Reset;
    logic              Busy;
    logic              Done;
    logic              Err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s_cyc;
    int base;

    int          wr_addr [$];
    logic [31:0] wr_dat  [$];
    int          wr_cyc  [$];

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Word_Count  (Word_Count),
        .Byte_In     (Byte_In),
        .Byte_Valid  (Byte_Valid),
        .Byte_Ready  (Byte_Ready),
        .Mem_WrEn    (Mem_WrEn),
        .Mem_Addr    (Mem_Addr),
        .Mem_Data    (Mem_Data),
        .Fetch_Reset (Fetch_Reset),
        .Busy        (Busy),
        .Done        (Done),
        .Err         (Err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Log every write strobe seen mid-cycle: one entry per high cycle.
    always @(negedge Clk) begin
        if (Mem_WrEn === 1'b1) begin
            wr_addr.push_back(int'(Mem_Addr));
            wr_dat.push_back(Mem_Data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        Byte_In    = b;
        Byte_Valid = 1'b1;
        while (Byte_Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("rdy_timeout", 32'd0, 32'd1);
        tick();
        Byte_Valid = 1'b0;
    endtask

    task automatic start_load(input logic [ADDR_W:0] cnt);
        Word_Count = cnt;
        Start      = 1'b1;
        tick();
        Start      = 1'b0;
        s_cyc      = cyc;
    endtask

    // Runs from the cycle after the last data byte is accepted to DONE.
    task automatic end_load(input logic [7:0] cks);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cks);
`else
        if (cks === 8'hxx) check("cks_x", 32'd0, 32'd1);
        tick();
`endif
    endtask

    logic [7:0] v2 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] v5 [6] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hAA, 8'hBB};
    logic [7:0] v6 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Word_Count = '0; Byte_In = 8'h00; Byte_Valid = 1'b0;

        // 1: reset values, Fetch_Reset drops one edge after release
        repeat (3) tick();
        check("rst_fetch_reset", {31'd0, Fetch_Reset}, 32'd1);
        check("rst_busy",        {31'd0, Busy},        32'd0);
        check("rst_done",        {31'd0, Done},        32'd0);
        check("rst_ready",       {31'd0, Byte_Ready},  32'd0);
        check("rst_wren",        {31'd0, Mem_WrEn},    32'd0);
        check("rst_addr",        32'(Mem_Addr),        32'd0);
        check("rst_data",        Mem_Data,             32'd0);
        check("rst_err",         {31'd0, Err},         32'd0);
        Reset = 1'b0;
        #1;
        check("rel_fetch_reset_hold", {31'd0, Fetch_Reset}, 32'd1);
        tick();
        check("rel_fetch_reset_drop", {31'd0, Fetch_Reset}, 32'd0);

        // 4: zero-length load goes straight to DONE
        start_load('0);
        check("z_done",        {31'd0, Done},        32'd1);
        check("z_fetch_reset", {31'd0, Fetch_Reset}, 32'd0);
        check("z_busy",        {31'd0, Busy},        32'd0);
        tick();
        check("z_fetch_reset2", {31'd0, Fetch_Reset}, 32'd0);
        check("z_no_write",     32'(wr_addr.size()),   32'd0);

        // 2: two back-to-back words
        base = wr_addr.size();
        start_load(11'd2);
        check("t2_busy",  {31'd0, Busy},       32'd1);
        check("t2_ready", {31'd0, Byte_Ready}, 32'd1);
        check("t2_done_clr", {31'd0, Done},    32'd0);
        foreach (v2[i]) send_byte(v2[i]);
        check("t2_wren_hi", {31'd0, Mem_WrEn}, 32'd1);
        check("t2_addr1",   32'(Mem_Addr),     32'd1);
        check("t2_data1",   Mem_Data,          32'hDEADBEEF);
        end_load(8'hB4);
        check("t2_done",   {31'd0, Done},        32'd1);
        check("t2_frst",   {31'd0, Fetch_Reset}, 32'd0);
        check("t2_busy0",  {31'd0, Busy},        32'd0);
        check("t2_err",    {31'd0, Err},         32'd0);
        check("t2_nwr",    32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            check("t2_a0", 32'(wr_addr[base]),     32'd0);
            check("t2_d0", wr_dat[base],           32'h12345678);
            check("t2_c0", 32'(wr_cyc[base] - s_cyc),     32'd4);
            check("t2_a1", 32'(wr_addr[base+1]),   32'd1);
            check("t2_d1", wr_dat[base+1],         32'hDEADBEEF);
            check("t2_c1", 32'(wr_cyc[base+1] - s_cyc),   32'd9);
        end

        // 3: stall after byte 2, with a Start pulse that must be ignored
        base = wr_addr.size();
        start_load(11'd2);
        send_byte(v2[0]);
        send_byte(v2[1]);
        tick();
        Word_Count = 11'd5; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        for (int i = 2; i < 8; i++) send_byte(v2[i]);
        end_load(8'hB4);
        check("t3_done", {31'd0, Done}, 32'd1);
        check("t3_nwr",  32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            check("t3_d0", wr_dat[base],   32'h12345678);
            check("t3_c0", 32'(wr_cyc[base] - s_cyc),   32'd7);
            check("t3_d1", wr_dat[base+1], 32'hDEADBEEF);
            check("t3_c1", 32'(wr_cyc[base+1] - s_cyc), 32'd12);
        end

        // Clamp: oversize count loads exactly 2^ADDR_W words
        base = wr_addr.size();
        start_load(11'h7FF);
        for (int i = 0; i < 4096; i++) send_byte(8'(i));
        end_load(8'h00);
        check("cl_done", {31'd0, Done}, 32'd1);
        check("cl_err",  {31'd0, Err},  32'd0);
        check("cl_nwr",  32'(wr_addr.size() - base), 32'd1024);
        check("cl_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd1023);
        check("cl_last_data", wr_dat[wr_dat.size()-1],        32'hFFFEFDFC);

        // 5: reset after 6 bytes of a 2-word load, then reload word 0
        base = wr_addr.size();
        start_load(11'd2);
        foreach (v5[i]) send_byte(v5[i]);
        Reset = 1'b1;
        #1;
        check("t5_done",  {31'd0, Done},        32'd0);
        check("t5_busy",  {31'd0, Busy},        32'd0);
        check("t5_frst",  {31'd0, Fetch_Reset}, 32'd1);
        check("t5_ready", {31'd0, Byte_Ready},  32'd0);
        tick();
        Reset = 1'b0;
        tick();
        check("t5_nwr", 32'(wr_addr.size() - base), 32'd1);
        check("t5_a0",  32'(wr_addr[base]), 32'd0);
        check("t5_d0",  wr_dat[base],       32'h11223344);
        start_load(11'd1);
        foreach (v6[i]) send_byte(v6[i]);
        end_load(8'hF6);
        check("t5_nwr2", 32'(wr_addr.size() - base), 32'd2);
        check("t5_a1",   32'(wr_addr[wr_addr.size()-1]), 32'd0);
        check("t5_d1",   wr_dat[wr_dat.size()-1],        32'h04030201);
        check("t5_done2", {31'd0, Done}, 32'd1);
        check("t5_err",   {31'd0, Err},  32'd0);

`ifdef LOADER_CHECKSUM_EN
        // 6: bad checksum flags Err but still completes
        start_load(11'd1);
        foreach (v6[i]) send_byte(v6[i]);
        tick();
        check("t6_frst_wait", {31'd0, Fetch_Reset}, 32'd1);
        send_byte(8'h00);
        check("t6_err",  {31'd0, Err},  32'd1);
        check("t6_done", {31'd0, Done}, 32'd1);
        start_load(11'd1);
        check("t6_err_clr", {31'd0, Err}, 32'd0);
        foreach (v6[i]) send_byte(v6[i]);
        end_load(8'hF6);
        check("t6_err_ok", {31'd0, Err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
